// File: rtl/nla_pkg.sv
// Shared definitions for the nonlinear approximation engine.
package nla_pkg;

    localparam int unsigned NLA_DATA_W     = 16;
    localparam int unsigned NLA_ADDR_LINES = 4;
    localparam int unsigned COEFF_DEPTH    = 2 ** NLA_ADDR_LINES;

    // Loader phase: waiting for a sample, waiting for coefficients, or ready to evaluate.
    typedef enum logic [1:0] {
        LOAD_SIG  = 2'd0,
        LOAD_COEF = 2'd1,
        ARMED     = 2'd2
    } loader_state_e;

endpackage

// File: rtl/nla_input_loader.sv
// Write-side front end: moves host samples/coefficients into the signal register and
// coefficient buffer, and tells the evaluation controller when each is ready.
module nla_input_loader
    import nla_pkg::*;
#(
    parameter int unsigned DATA_W     = NLA_DATA_W,
    parameter int unsigned ADDR_LINES = NLA_ADDR_LINES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_is_coeff,
    input  logic                  in_last,
    input  logic                  coeff_reload,
    input  logic                  wr_en_signal,
    input  logic                  wr_en_coeff,
    input  logic                  LD_result,
    output logic                  sig_we,
    output logic [DATA_W-1:0]     sig_wdata,
    output logic                  coeff_we,
    output logic [ADDR_LINES-1:0] coeff_waddr,
    output logic [DATA_W-1:0]     coeff_wdata,
    output logic                  start_signal,
    output logic                  start_coeff,
    output logic [ADDR_LINES-1:0] wr_ptr_coeff,
    output logic                  err_overflow
);

    localparam logic [ADDR_LINES-1:0] ADDR_MAX = '1;

    loader_state_e         state_q, state_d;
    logic                  start_coeff_q, start_coeff_d;
    logic                  reload_pend_q, reload_pend_d;
    logic                  err_q, err_d;
    logic [ADDR_LINES-1:0] waddr_q, waddr_d;
    logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d;

    logic sig_hs, coef_hs, set_done, armed;

    // Handshake gating: a type is accepted only while granted and its flag is still low.
    assign in_ready = (!in_is_coeff && wr_en_signal && !start_signal)
                    || (in_is_coeff && wr_en_coeff && !start_coeff_q);
    assign sig_hs   = in_valid && in_ready && !in_is_coeff;
    assign coef_hs  = in_valid && in_ready && in_is_coeff;
    assign set_done = in_last || (waddr_q == ADDR_MAX);
    assign armed    = (state_q == ARMED);

    assign sig_we       = sig_hs;
    assign sig_wdata    = in_data;
    assign coeff_we     = coef_hs;
    assign coeff_waddr  = waddr_q;
    assign coeff_wdata  = in_data;
    assign start_signal = (state_q != LOAD_SIG);
    assign start_coeff  = start_coeff_q;
    assign wr_ptr_coeff = wr_ptr_q;
    assign err_overflow = err_q;

    always_comb begin
        state_d       = state_q;
        start_coeff_d = start_coeff_q;
        reload_pend_d = reload_pend_q;
        err_d         = err_q;
        waddr_d       = waddr_q;
        wr_ptr_d      = wr_ptr_q;

        case (state_q)
            LOAD_SIG: begin
                if (sig_hs) state_d = start_coeff_q ? ARMED : LOAD_COEF;
            end
            LOAD_COEF: begin
                if (LD_result)                state_d = LOAD_SIG;
                else if (coef_hs && set_done) state_d = ARMED;
            end
            ARMED: begin
                if (LD_result) state_d = LOAD_SIG;
            end
            default: state_d = LOAD_SIG;
        endcase

        if (coef_hs) begin
            wr_ptr_d = waddr_q;
            if (set_done) begin
                start_coeff_d = 1'b1;
                waddr_d       = '0;
                err_d         = err_q || !in_last;
            end else begin
                waddr_d = waddr_q + ADDR_LINES'(1);
            end
        end

        // A reload while armed waits for the running evaluation to finish.
        if (coeff_reload && start_coeff_q) begin
            if (armed && !LD_result) begin
                reload_pend_d = 1'b1;
            end else if (!armed) begin
                start_coeff_d = 1'b0;
                waddr_d       = '0;
            end
        end

        if (LD_result && (reload_pend_q || (coeff_reload && armed))) begin
            start_coeff_d = 1'b0;
            reload_pend_d = 1'b0;
            waddr_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOAD_SIG;
            start_coeff_q <= 1'b0;
            reload_pend_q <= 1'b0;
            err_q         <= 1'b0;
            waddr_q       <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            start_coeff_q <= start_coeff_d;
            reload_pend_q <= reload_pend_d;
            err_q         <= err_d;
            waddr_q       <= waddr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

endmodule

// File: tb/tb_nla_input_loader.sv
// Bench for nla_input_loader: default instance checked against a behavioural model every
// cycle, plus a 4-deep instance for the capacity-truncation case.
module tb_nla_input_loader;

    bit          clk;
    logic        rst_n;
    logic [1:0]  vld, isc, lst, rld, ldr, wes, wec;
    logic [15:0] dat0, dat1;
    logic [1:0]  rdy, swe, cwe, ss, sc, err;
    logic [15:0] swd0, swd1, cwd0, cwd1;
    logic [3:0]  cwa0, ptr0;
    logic [1:0]  cwa1, ptr1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nla_input_loader #(.DATA_W(16), .ADDR_LINES(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat0),
        .in_is_coeff(isc[0]), .in_last(lst[0]), .coeff_reload(rld[0]),
        .wr_en_signal(wes[0]), .wr_en_coeff(wec[0]), .LD_result(ldr[0]),
        .sig_we(swe[0]), .sig_wdata(swd0), .coeff_we(cwe[0]), .coeff_waddr(cwa0),
        .coeff_wdata(cwd0), .start_signal(ss[0]), .start_coeff(sc[0]),
        .wr_ptr_coeff(ptr0), .err_overflow(err[0])
    );

    nla_input_loader #(.DATA_W(16), .ADDR_LINES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat1),
        .in_is_coeff(isc[1]), .in_last(lst[1]), .coeff_reload(rld[1]),
        .wr_en_signal(wes[1]), .wr_en_coeff(wec[1]), .LD_result(ldr[1]),
        .sig_we(swe[1]), .sig_wdata(swd1), .coeff_we(cwe[1]), .coeff_waddr(cwa1),
        .coeff_wdata(cwd1), .start_signal(ss[1]), .start_coeff(sc[1]),
        .wr_ptr_coeff(ptr1), .err_overflow(err[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of u0: flags, address counter and per-cycle write strobes.
    logic       m_ss, m_sc, m_err, m_pend;
    logic [3:0] m_waddr, m_ptr;

    initial begin
        logic       e_rdy, hs_s, hs_c, n_ss, n_sc, n_err, n_pend;
        logic [3:0] n_waddr, n_ptr;
        m_ss = 0; m_sc = 0; m_err = 0; m_pend = 0; m_waddr = 0; m_ptr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ss = 0; m_sc = 0; m_err = 0; m_pend = 0; m_waddr = 0; m_ptr = 0;
                chk("rst_start_signal", 32'(ss[0]), 0);
                chk("rst_start_coeff", 32'(sc[0]), 0);
                chk("rst_wr_ptr", 32'(ptr0), 0);
                chk("rst_err", 32'(err[0]), 0);
                n_ss = 0; n_sc = 0; n_err = 0; n_pend = 0; n_waddr = 0; n_ptr = 0;
            end else begin
                e_rdy = isc[0] ? (wec[0] && !m_sc) : (wes[0] && !m_ss);
                hs_s  = vld[0] && e_rdy && !isc[0];
                hs_c  = vld[0] && e_rdy && isc[0];
                chk("m_in_ready", 32'(rdy[0]), 32'(e_rdy));
                chk("m_sig_we", 32'(swe[0]), 32'(hs_s));
                chk("m_coeff_we", 32'(cwe[0]), 32'(hs_c));
                if (hs_s) chk("m_sig_wdata", 32'(swd0), 32'(dat0));
                if (hs_c) begin
                    chk("m_coeff_waddr", 32'(cwa0), 32'(m_waddr));
                    chk("m_coeff_wdata", 32'(cwd0), 32'(dat0));
                end
                chk("m_start_signal", 32'(ss[0]), 32'(m_ss));
                chk("m_start_coeff", 32'(sc[0]), 32'(m_sc));
                chk("m_wr_ptr", 32'(ptr0), 32'(m_ptr));
                chk("m_err", 32'(err[0]), 32'(m_err));

                n_ss = m_ss ? !ldr[0] : hs_s;
                n_sc = m_sc; n_err = m_err; n_pend = m_pend; n_waddr = m_waddr; n_ptr = m_ptr;
                if (hs_c) begin
                    n_ptr = m_waddr;
                    if (lst[0] || m_waddr == 4'd15) begin
                        n_sc = 1; n_waddr = 0;
                        if (!lst[0]) n_err = 1;
                    end else begin
                        n_waddr = m_waddr + 4'd1;
                    end
                end
                if (m_ss && m_sc) begin
                    if (ldr[0] && (m_pend || rld[0])) begin
                        n_sc = 0; n_pend = 0; n_waddr = 0;
                    end else if (rld[0]) begin
                        n_pend = 1;
                    end
                end else if (m_sc && rld[0]) begin
                    n_sc = 0; n_waddr = 0;
                end
            end
            @(posedge clk);
            m_ss = n_ss; m_sc = n_sc; m_err = n_err; m_pend = n_pend;
            m_waddr = n_waddr; m_ptr = n_ptr;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one word to instance sel and hold it until accepted; addr is the write address seen.
    task automatic send(input bit sel, input logic c, input logic [15:0] d, input logic l,
                        output int addr);
        int n = 0;
        addr = -1;
        isc[sel] = c; lst[sel] = l; vld[sel] = 1'b1;
        if (sel) dat1 = d; else dat0 = d;
        forever begin
            @(negedge clk);
            if (rdy[sel]) begin
                addr = sel ? int'(cwa1) : int'(cwa0);
                break;
            end
            n++;
            if (n > 20) begin
                n_chk++; n_err++;
                $display("FAIL send_timeout: word 0x%0h never accepted on dut %0d", d, sel);
                break;
            end
        end
        tick();
        vld[sel] = 1'b0; lst[sel] = 1'b0;
    endtask

    task automatic pulse(input logic do_ld, input logic do_rld);
        ldr[0] = do_ld; rld[0] = do_rld;
        tick();
        ldr[0] = 1'b0; rld[0] = 1'b0;
    endtask

    initial begin
        int a;
        rst_n = 0;
        vld = '0; isc = '0; lst = '0; rld = '0; ldr = '0;
        wes = '1; wec = '1; dat0 = '0; dat1 = '0;

        repeat (2) @(negedge clk);
        chk("reset_start_signal", 32'(ss[0]), 0);
        chk("reset_err_u1", 32'(err[1]), 0);
        tick();
        rst_n = 1;

        // Basic load
        send(0, 0, 16'h0100, 0, a);
        send(0, 1, 16'h000A, 0, a); chk("basic_addr0", 32'(a), 0);
        send(0, 1, 16'h000B, 0, a); chk("basic_addr1", 32'(a), 1);
        send(0, 1, 16'h000C, 1, a); chk("basic_addr2", 32'(a), 2);
        @(negedge clk);
        chk("basic_start_coeff", 32'(sc[0]), 1);
        chk("basic_wr_ptr", 32'(ptr0), 2);
        tick();

        // Coefficient persistence across samples
        pulse(1, 0);
        @(negedge clk);
        chk("persist_sig_low", 32'(ss[0]), 0);
        chk("persist_coeff_kept", 32'(sc[0]), 1);
        tick();
        send(0, 0, 16'h0200, 0, a);
        @(negedge clk);
        chk("persist_sig_high", 32'(ss[0]), 1);
        tick();

        // Deferred reload
        pulse(0, 1);
        @(negedge clk);
        chk("defer_coeff_held", 32'(sc[0]), 1);
        tick();
        pulse(1, 0);
        @(negedge clk);
        chk("defer_coeff_clear", 32'(sc[0]), 0);
        chk("defer_ptr_holds", 32'(ptr0), 2);
        tick();
        send(0, 0, 16'h0300, 0, a);
        send(0, 1, 16'h0011, 0, a); chk("defer_new_addr0", 32'(a), 0);
        send(0, 1, 16'h0022, 1, a); chk("defer_new_addr1", 32'(a), 1);

        // Immediate reload once the sample has been consumed
        pulse(1, 0);
        pulse(0, 1);
        @(negedge clk);
        chk("imm_reload_clear", 32'(sc[0]), 0);
        tick();
        send(0, 0, 16'h0310, 0, a);
        send(0, 1, 16'h0033, 1, a); chk("imm_reload_addr0", 32'(a), 0);

        // Simultaneous LD_result and reload while armed
        pulse(1, 1);
        @(negedge clk);
        chk("simul_sig_clear", 32'(ss[0]), 0);
        chk("simul_coeff_clear", 32'(sc[0]), 0);
        tick();

        // Stall on withheld coefficient grant
        send(0, 0, 16'h0400, 0, a);
        wec[0] = 0; isc[0] = 1; dat0 = 16'h0044; vld[0] = 1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", 32'(rdy[0]), 0);
            chk("stall_no_write", 32'(cwe[0]), 0);
            tick();
        end
        vld[0] = 0; wec[0] = 1;
        send(0, 1, 16'h0044, 0, a); chk("stall_release_addr0", 32'(a), 0);
        send(0, 1, 16'h0055, 0, a); chk("stall_release_addr1", 32'(a), 1);

        // Reset mid-set
        rst_n = 0;
        @(negedge clk);
        chk("midrst_start_signal", 32'(ss[0]), 0);
        chk("midrst_wr_ptr", 32'(ptr0), 0);
        tick();
        rst_n = 1;
        send(0, 0, 16'h0500, 0, a);
        send(0, 1, 16'h0066, 1, a); chk("postrst_addr0", 32'(a), 0);
        @(negedge clk);
        chk("postrst_start_coeff", 32'(sc[0]), 1);
        tick();

        // Overflow on the 4-deep instance
        send(1, 0, 16'h0700, 0, a);
        for (int i = 0; i < 4; i++) begin
            send(1, 1, 16'h0071 + 16'(i), 0, a);
            chk("ovf_addr", 32'(a), 32'(i));
        end
        @(negedge clk);
        chk("ovf_start_coeff", 32'(sc[1]), 1);
        chk("ovf_err", 32'(err[1]), 1);
        chk("ovf_wr_ptr", 32'(ptr1), 3);
        tick();
        isc[1] = 1; lst[1] = 1; dat1 = 16'h0075; vld[1] = 1;
        repeat (3) begin
            @(negedge clk);
            chk("ovf_fifth_ready", 32'(rdy[1]), 0);
            chk("ovf_fifth_no_write", 32'(cwe[1]), 0);
            tick();
        end
        vld[1] = 0; lst[1] = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
